// File: rtl/rf_pkg.sv
// Shared constants and bus helpers for the multi-port register file.
// Packed buses carry one fixed-width slot per port, slot k at [k*w +: w].
package rf_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned ZERO_REG   = 0;

    // Widest slot and largest port count the slot helper supports.
    localparam int unsigned SLOT_MAX_W = 64;
    localparam int unsigned SLOT_MAX_N = 4;
    localparam int unsigned SLOT_BUS_W = SLOT_MAX_W * SLOT_MAX_N;

    typedef logic [SLOT_BUS_W-1:0] slot_bus_t;
    typedef logic [SLOT_MAX_W-1:0] slot_t;

    // Return slot k of width w from a packed bus, zero-extended to SLOT_MAX_W.
    function automatic slot_t get_slot(input slot_bus_t bus, input int unsigned k,
                                       input int unsigned w);
        slot_t mask;
        mask = ~({SLOT_MAX_W{1'b1}} << w);
        return slot_t'(bus >> (k * w)) & mask;
    endfunction

endpackage

// File: rtl/rf_write_select.sv
// Matches one query address against every write port; the highest-index
// enabled port targeting a non-zero query wins.
module rf_write_select
    import rf_pkg::*;
#(
    parameter int unsigned NUM_WRITE = 2,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W
) (
    input  logic [NUM_WRITE-1:0]        should_write,
    input  logic [NUM_WRITE*ADDR_W-1:0] write_addr,
    input  logic [NUM_WRITE*DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0]           query_addr,
    output logic                        hit,
    output logic [DATA_W-1:0]           data
);

    logic [ADDR_W-1:0] port_addr [NUM_WRITE];
    logic [DATA_W-1:0] port_data [NUM_WRITE];

    for (genvar k = 0; k < NUM_WRITE; k++) begin : g_unpack
        assign port_addr[k] = ADDR_W'(get_slot(slot_bus_t'(write_addr), k, ADDR_W));
        assign port_data[k] = DATA_W'(get_slot(slot_bus_t'(write_data), k, DATA_W));
    end

    always_comb begin
        hit  = 1'b0;
        data = '0;
        // Ascending scan so a later (higher-index) match overrides earlier ones.
        for (int unsigned k = 0; k < NUM_WRITE; k++) begin
            if (should_write[k] && (port_addr[k] == query_addr) &&
                (query_addr != ADDR_W'(ZERO_REG))) begin
                hit  = 1'b1;
                data = port_data[k];
            end
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with per-register busy scoreboard,
// optional write-to-read bypass and a hardwired-zero register 0.
module register_file_mp
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned NUM_READ  = 2,
    parameter int unsigned NUM_WRITE = 2,
    parameter int unsigned BYPASS    = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_WRITE-1:0]        should_write,
    input  logic [NUM_WRITE*ADDR_W-1:0] write_addr,
    input  logic [NUM_WRITE*DATA_W-1:0] write_data,
    input  logic [NUM_READ*ADDR_W-1:0]  read_addr,
    output logic [NUM_READ*DATA_W-1:0]  read_data,
    input  logic                        claim_en,
    input  logic [ADDR_W-1:0]           claim_addr,
    output logic [NUM_READ-1:0]         read_busy,
    output logic [2**ADDR_W-1:0]        busy_vec
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] reg_hit;
    logic [DATA_W-1:0]   reg_wdata [NUM_REGS];

    // One selector per register resolves port conflicts for the storage update.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg_sel
        rf_write_select #(
            .NUM_WRITE (NUM_WRITE),
            .ADDR_W    (ADDR_W),
            .DATA_W    (DATA_W)
        ) u_sel (
            .should_write (should_write),
            .write_addr   (write_addr),
            .write_data   (write_data),
            .query_addr   (ADDR_W'(r)),
            .hit          (reg_hit[r]),
            .data         (reg_wdata[r])
        );
    end

    // Claim is applied after the write-clear so a same-cycle claim keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (reg_hit[r]) begin
                busy_d[r] = 1'b0;
            end
            if (claim_en && (claim_addr == ADDR_W'(r))) begin
                busy_d[r] = 1'b1;
            end
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                if (reg_hit[r]) begin
                    regs_q[r] <= reg_wdata[r];
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_read
        logic [ADDR_W-1:0] raddr;
        logic              fwd_hit;
        logic [DATA_W-1:0] fwd_data;
        logic              use_fwd;

        assign raddr = ADDR_W'(get_slot(slot_bus_t'(read_addr), i, ADDR_W));

        rf_write_select #(
            .NUM_WRITE (NUM_WRITE),
            .ADDR_W    (ADDR_W),
            .DATA_W    (DATA_W)
        ) u_byp (
            .should_write (should_write),
            .write_addr   (write_addr),
            .write_data   (write_data),
            .query_addr   (raddr),
            .hit          (fwd_hit),
            .data         (fwd_data)
        );

        // Forwarded data is already valid, so it also masks the pending flag.
        assign use_fwd = (BYPASS != 0) && fwd_hit;

        assign read_data[i*DATA_W +: DATA_W] =
            (raddr == ADDR_W'(ZERO_REG)) ? '0 :
            use_fwd                      ? fwd_data : regs_q[raddr];
        assign read_busy[i] = busy_q[raddr] && !use_fwd;
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Randomised bench for register_file_mp: drives a BYPASS=1 and a BYPASS=0 instance
// with identical stimulus and checks both against an array-based reference model.
module tb_register_file_mp;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NR    = 2;
    localparam int unsigned NW    = 2;
    localparam int unsigned NREGS = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [NW-1:0]    should_write;
    logic [NW*AW-1:0] write_addr;
    logic [NW*DW-1:0] write_data;
    logic [NR*AW-1:0] read_addr;
    logic             claim_en;
    logic [AW-1:0]    claim_addr;

    logic [NR*DW-1:0] rd_byp, rd_nob;
    logic [NR-1:0]    rb_byp, rb_nob;
    logic [NREGS-1:0] bv_byp, bv_nob;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [DW-1:0] mregs [NREGS];
    bit            mbusy [NREGS];

    always #5 clk = ~clk;

    register_file_mp #(
        .DATA_W (DW), .ADDR_W (AW), .NUM_READ (NR), .NUM_WRITE (NW), .BYPASS (1)
    ) u_dut_byp (
        .clk          (clk),
        .reset        (reset),
        .should_write (should_write),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .read_addr    (read_addr),
        .read_data    (rd_byp),
        .claim_en     (claim_en),
        .claim_addr   (claim_addr),
        .read_busy    (rb_byp),
        .busy_vec     (bv_byp)
    );

    register_file_mp #(
        .DATA_W (DW), .ADDR_W (AW), .NUM_READ (NR), .NUM_WRITE (NW), .BYPASS (0)
    ) u_dut_nob (
        .clk          (clk),
        .reset        (reset),
        .should_write (should_write),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .read_addr    (read_addr),
        .read_data    (rd_nob),
        .claim_en     (claim_en),
        .claim_addr   (claim_addr),
        .read_busy    (rb_nob),
        .busy_vec     (bv_nob)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference read: stored value, optionally overridden by this cycle's writes.
    function automatic logic [DW-1:0] m_read(input int unsigned a, input bit byp);
        logic [DW-1:0] v;
        if (a == 0) return '0;
        v = mregs[a];
        if (byp) begin
            for (int unsigned k = 0; k < NW; k++) begin
                if (should_write[k] && (write_addr[k*AW +: AW] == AW'(a))) v = write_data[k*DW +: DW];
            end
        end
        return v;
    endfunction

    function automatic bit m_busy(input int unsigned a, input bit byp);
        bit b;
        if (a == 0) return 1'b0;
        b = mbusy[a];
        if (byp) begin
            for (int unsigned k = 0; k < NW; k++) begin
                if (should_write[k] && (write_addr[k*AW +: AW] == AW'(a))) b = 1'b0;
            end
        end
        return b;
    endfunction

    function automatic logic [NREGS-1:0] m_busy_vec();
        logic [NREGS-1:0] v;
        for (int unsigned r = 0; r < NREGS; r++) v[r] = mbusy[r];
        return v;
    endfunction

    task automatic settle();
        int unsigned a;
        #3;
        for (int unsigned i = 0; i < NR; i++) begin
            a = int'(read_addr[i*AW +: AW]);
            check_eq($sformatf("rdata_byp%0d_a%0d", i, a), 64'(rd_byp[i*DW +: DW]), 64'(m_read(a, 1'b1)));
            check_eq($sformatf("rdata_nob%0d_a%0d", i, a), 64'(rd_nob[i*DW +: DW]), 64'(m_read(a, 1'b0)));
            check_eq($sformatf("rbusy_byp%0d_a%0d", i, a), 64'(rb_byp[i]), 64'(m_busy(a, 1'b1)));
            check_eq($sformatf("rbusy_nob%0d_a%0d", i, a), 64'(rb_nob[i]), 64'(m_busy(a, 1'b0)));
        end
        check_eq("busy_vec_byp", 64'(bv_byp), 64'(m_busy_vec()));
        check_eq("busy_vec_nob", 64'(bv_nob), 64'(m_busy_vec()));
    endtask

    // Clock edge plus model update from the inputs that were present at the edge.
    task automatic tick();
        int unsigned a;
        @(posedge clk);
        if (reset) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                mregs[r] = '0;
                mbusy[r] = 1'b0;
            end
        end else begin
            for (int unsigned k = 0; k < NW; k++) begin
                a = int'(write_addr[k*AW +: AW]);
                if (should_write[k] && a != 0) begin
                    mregs[a] = write_data[k*DW +: DW];
                    mbusy[a] = 1'b0;
                end
            end
            if (claim_en && claim_addr != 0) mbusy[claim_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        should_write = '0;
        write_addr   = '0;
        write_data   = '0;
        claim_en     = 1'b0;
        claim_addr   = '0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREGS - 1));
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        reset     = 1'b1;
        read_addr = '0;
        idle();
        for (int unsigned r = 0; r < NREGS; r++) begin
            mregs[r] = '0;
            mbusy[r] = 1'b0;
        end
        tick();
        tick();
        reset = 1'b0;

        for (int unsigned a = 0; a < NREGS; a++) begin
            read_addr = {AW'(NREGS - 1 - a), AW'(a)};
            settle();
        end

        // Write to r0 is dropped; disabled port does not write r1.
        should_write = 2'b01;
        write_addr   = {5'd1, 5'd0};
        write_data   = {32'h0000_1234, 32'hFFFF_FFFF};
        read_addr    = {5'd1, 5'd0};
        settle();
        check_eq("zero_reg_fwd", 64'(rd_byp[31:0]), 64'h0);
        tick();
        idle();
        settle();
        check_eq("zero_reg_after", 64'(rd_byp[31:0]), 64'h0);
        check_eq("disabled_port_r1", 64'(rd_byp[63:32]), 64'h0);

        // Conflict on r3: port 1 wins.
        should_write = 2'b11;
        write_addr   = {5'd3, 5'd3};
        write_data   = {32'h22, 32'h11};
        read_addr    = {5'd0, 5'd3};
        settle();
        check_eq("conflict_fwd", 64'(rd_byp[31:0]), 64'h22);
        tick();
        idle();
        settle();
        check_eq("conflict_byp", 64'(rd_byp[31:0]), 64'h22);
        check_eq("conflict_nob", 64'(rd_nob[31:0]), 64'h22);

        // Without bypass the old value is seen during the write cycle.
        should_write = 2'b01;
        write_addr   = {5'd0, 5'd5};
        write_data   = {32'h0, 32'h7};
        tick();
        write_data   = {32'h0, 32'h9};
        read_addr    = {5'd0, 5'd5};
        settle();
        check_eq("nob_old_value", 64'(rd_nob[31:0]), 64'h7);
        check_eq("byp_new_value", 64'(rd_byp[31:0]), 64'h9);
        tick();
        idle();
        settle();
        check_eq("nob_new_value", 64'(rd_nob[31:0]), 64'h9);

        // Claim r4, then release it with a write.
        claim_en   = 1'b1;
        claim_addr = 5'd4;
        tick();
        idle();
        read_addr = {5'd0, 5'd4};
        settle();
        check_eq("claim_busy", 64'(rb_byp[0]), 64'h1);
        should_write = 2'b01;
        write_addr   = {5'd0, 5'd4};
        write_data   = {32'h0, 32'hA5};
        settle();
        check_eq("release_fwd_busy", 64'(rb_byp[0]), 64'h0);
        check_eq("release_fwd_data", 64'(rd_byp[31:0]), 64'hA5);
        check_eq("release_nob_busy", 64'(rb_nob[0]), 64'h1);
        tick();
        idle();
        settle();
        check_eq("release_vec", 64'(bv_byp[4]), 64'h0);

        // Same-cycle claim and write to r6: claim wins, data still stored.
        claim_en     = 1'b1;
        claim_addr   = 5'd6;
        should_write = 2'b10;
        write_addr   = {5'd6, 5'd0};
        write_data   = {32'h66, 32'h0};
        tick();
        idle();
        read_addr = {5'd0, 5'd6};
        settle();
        check_eq("claim_wins_vec", 64'(bv_byp[6]), 64'h1);
        check_eq("claim_wins_data", 64'(rd_nob[31:0]), 64'h66);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        check_eq("reset_vec", 64'(bv_byp), 64'h0);
        check_eq("reset_data", 64'(rd_byp[31:0]), 64'h0);

        for (int n = 0; n < 3000; n++) begin
            reset        = ($urandom_range(0, 63) == 0);
            should_write = NW'($urandom);
            write_addr   = {rand_addr(), rand_addr()};
            write_data   = {32'($urandom), 32'($urandom)};
            read_addr    = {rand_addr(), rand_addr()};
            claim_en     = ($urandom_range(0, 2) == 0);
            claim_addr   = rand_addr();
            settle();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port integer register file with a per-register scoreboard; successor to the single-write, dual-read register file.
- Sits between decode/issue and writeback in the core. Issue claims destination registers; writeback ports commit results and release claims.
- Provides N read ports, M write ports, optional same-cycle write-to-read bypass, and a hardwired-zero register 0.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; register count = 2**ADDR_W.
- NUM_READ, 2, number of read ports (1..4).
- NUM_WRITE, 2, number of write ports (1..3).
- BYPASS, 1, 1 = a read sees same-cycle write data; 0 = a read sees the stored value only.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all registers and busy bits.
- should_write  in  NUM_WRITE  per-port write enable.
- write_addr  in  NUM_WRITE*ADDR_W  write indices; port k occupies bits [k*ADDR_W +: ADDR_W].
- write_data  in  NUM_WRITE*DATA_W  write data, packed the same way.
- read_addr  in  NUM_READ*ADDR_W  read indices, packed.
- read_data  out  NUM_READ*DATA_W  read data, packed.
- claim_en  in  1  marks claim_addr as pending (the issue stage allocates a destination).
- claim_addr  in  ADDR_W  register to mark busy.
- read_busy  out  NUM_READ  per read port: the addressed register is pending.
- busy_vec  out  2**ADDR_W  raw scoreboard bits; bit 0 is always 0.

Behaviour:
- Storage: array regs[2**ADDR_W] of DATA_W bits, plus busy[2**ADDR_W].
- Reset, when reset=1 at a clk rising edge:
  - all regs become 0 and all busy bits become 0;
  - writes and claims in that cycle are ignored;
  - outputs reflect the cleared state from the next cycle;
  - reset asserted mid-stream discards all pending claims.
- Writes:
  - at the rising edge, regs[write_addr[k]] <= write_data[k] for each k with should_write[k]=1 and write_addr[k]!=0;
  - a write to address 0 is always dropped.
- Write conflict: if two enabled ports target the same non-zero address, the highest-index port wins; the others are discarded silently.
- Read latency is zero (combinational from read_addr):
  - read_addr=0 returns 0 regardless of writes;
  - BYPASS=1: if any enabled write port targets the address this cycle, return that port's data (highest index wins on conflict); otherwise return regs[addr];
  - BYPASS=0: always return regs[addr]; new data is visible from the cycle after the write edge.
- Scoreboard update at the rising edge, evaluated per address:
  - claim_en=1 and claim_addr!=0 sets busy[claim_addr];
  - any enabled write to an address clears its busy bit;
  - a claim and a write to the same address in the same cycle leave busy=1 (claim wins; the write data is still stored);
  - a claim to address 0 is ignored; busy[0] is constant 0.
- read_busy[i]:
  - BYPASS=1: busy[read_addr[i]] AND NOT (an enabled write to that address this cycle), because forwarded data is valid;
  - BYPASS=0: busy[read_addr[i]].
- Writes to non-busy registers are legal and do not change busy.
- Reset values of outputs: read_data=0 for every address, read_busy=0, busy_vec=0.

Decomposition:
- Shared package rf_pkg holds:
  - default width constants (DATA_W=32, ADDR_W=5);
  - a function that unpacks slot k of a packed bus;
  - the ZERO_REG=0 constant.
- One natural sub-module: rf_write_select. It is combinational and takes NUM_WRITE enables/addresses/data plus a query address. It returns hit and the highest-priority data.
- rf_write_select is instantiated once per read port for bypass and reused per register for storage update.

Test Plan:
- Reset for 2 cycles, then read all ports at addresses 0..31 -> every read_data=0, busy_vec=0.
- Write port0 (addr 0, data 0xFFFFFFFF) and port1 (addr 1, should_write=0) -> reads of addr 0 and addr 1 both return 0.
- Same cycle: port0 writes addr 3=0x11 and port1 writes addr 3=0x22, read_addr0=3 -> with BYPASS=1, read_data0=0x22 that cycle; the next cycle read_data0=0x22 under both BYPASS settings.
- BYPASS=0: regs[5]=7, then write addr 5=9 while reading 5 -> read returns 7 that cycle and 9 the next.
- Claim addr 4, next cycle read 4 -> read_busy=1. Then write addr 4=0xA5 -> with BYPASS=1, read_busy=0 in the same cycle and read_data=0xA5; busy_vec[4]=0 after the edge.
- Claim addr 6 together with a write to addr 6 in the same cycle -> busy_vec[6]=1 after the edge and regs[6] is updated. Then assert reset for 1 cycle -> busy_vec=0 and a read of 6 returns 0.
